// File: rtl/bus_decode.sv
// 68000 address decoder and bus-cycle supervisor: chip selects, boot overlay
// and a /BERR watchdog for unmapped or unanswered accesses.
module bus_decode #(
    parameter int BOOT_CYCLES  = 4,
    parameter int BERR_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] addr,
    input  logic [2:0] fc,
    input  logic       as_n,
    input  logic       uds_n,
    input  logic       lds_n,
    input  logic       rw,
    input  logic       dtack_n,
    output logic       ram_evn_cs,
    output logic       ram_odd_cs,
    output logic       rom_evn_cs,
    output logic       rom_odd_cs,
    output logic       duart_cs,
    output logic       berr_n,
    output logic       overlay
);

    localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES);
    localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(BERR_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_ACTIVE,
        WD_BERR
    } wd_state_t;

    logic              is_ram;
    logic              is_rom;
    logic              is_duart;
    logic              iack;
    logic              unmapped;
    logic              redirect;

    logic              as_n_q, as_n_d;
    logic              rw_last_q, rw_last_d;
    logic              rom_seen_q, rom_seen_d;
    logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [BOOT_W-1:0] boot_inc;
    logic              overlay_q, overlay_d;
    logic              as_rise;

    wd_state_t         wd_state_q, wd_state_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              berr_n_q, berr_n_d;

    always_comb begin
        is_ram   = (addr[4:1] == 4'b0000);
        is_rom   = (addr == 5'b11100);
        is_duart = (addr == 5'b11101);
        iack     = (fc == 3'b111);
        unmapped = !iack && !(is_ram || is_rom || is_duart);
        redirect = overlay_q && rw && is_ram;
    end

    // Selects are purely combinational so they release in the cycle as_n rises.
    always_comb begin
        ram_evn_cs = 1'b1;
        ram_odd_cs = 1'b1;
        rom_evn_cs = 1'b1;
        rom_odd_cs = 1'b1;
        duart_cs   = 1'b1;
        if (reset && !as_n && !iack) begin
            if (is_ram && !redirect) begin
                ram_evn_cs = uds_n;
                ram_odd_cs = lds_n;
            end
            if (is_rom || redirect) begin
                rom_evn_cs = uds_n;
                rom_odd_cs = lds_n;
            end
            if (is_duart) begin
                duart_cs = 1'b0;
            end
        end
    end

    always_comb begin
        as_n_d     = as_n;
        as_rise    = as_n && !as_n_q;
        rw_last_d  = as_n ? rw_last_q : rw;
        rom_seen_d = as_n ? 1'b0 : (rom_seen_q || (is_rom && !iack));
        boot_inc   = boot_cnt_q + BOOT_W'(1);
        boot_cnt_d = boot_cnt_q;
        overlay_d  = overlay_q;
        if (as_rise && overlay_q) begin
            if (rw_last_q) begin
                boot_cnt_d = boot_inc;
                if (boot_inc == BOOT_LAST) begin
                    overlay_d = 1'b0;
                end
            end
            if (rom_seen_q) begin
                overlay_d = 1'b0;
            end
        end
    end

    // Watchdog: dtack_n low freezes the count; the count saturates at all-ones.
    always_comb begin
        wd_state_d = wd_state_q;
        wd_cnt_d   = wd_cnt_q;
        if (as_n) begin
            wd_state_d = WD_IDLE;
            wd_cnt_d   = '0;
        end else begin
            case (wd_state_q)
                WD_IDLE: begin
                    wd_cnt_d   = CNT_W'(1);
                    wd_state_d = unmapped ? WD_BERR : WD_ACTIVE;
                end
                WD_ACTIVE: begin
                    if (unmapped) begin
                        wd_state_d = WD_BERR;
                    end else if (!dtack_n) begin
                        wd_cnt_d = wd_cnt_q;
                    end else if (wd_cnt_q == TIMEOUT) begin
                        wd_state_d = WD_BERR;
                    end else if (wd_cnt_q != CNT_MAX) begin
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    end
                end
                WD_BERR: begin
                    wd_state_d = WD_BERR;
                end
                default: begin
                    wd_state_d = WD_IDLE;
                end
            endcase
        end
        berr_n_d = (wd_state_d != WD_BERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            as_n_q     <= 1'b1;
            rw_last_q  <= 1'b0;
            rom_seen_q <= 1'b0;
            boot_cnt_q <= '0;
            overlay_q  <= 1'b1;
            wd_state_q <= WD_IDLE;
            wd_cnt_q   <= '0;
            berr_n_q   <= 1'b1;
        end else begin
            as_n_q     <= as_n_d;
            rw_last_q  <= rw_last_d;
            rom_seen_q <= rom_seen_d;
            boot_cnt_q <= boot_cnt_d;
            overlay_q  <= overlay_d;
            wd_state_q <= wd_state_d;
            wd_cnt_q   <= wd_cnt_d;
            berr_n_q   <= berr_n_d;
        end
    end

    assign berr_n  = berr_n_q;
    assign overlay = overlay_q;

endmodule

// File: tb/tb_bus_decode.sv
// Directed-vector bench for bus_decode: boot overlay, chip selects, watchdog
// timeout/unmapped /BERR and asynchronous reset.
module tb_bus_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] addr;
    logic [2:0] fc;
    logic       as_n, uds_n, lds_n, rw, dtack_n;
    logic       ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs;
    logic       berr_n, overlay;
    logic [4:0] cs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cs = {ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs};

    bus_decode #(.BOOT_CYCLES(4), .BERR_TIMEOUT(64), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .fc         (fc),
        .as_n       (as_n),
        .uds_n      (uds_n),
        .lds_n      (lds_n),
        .rw         (rw),
        .dtack_n    (dtack_n),
        .ram_evn_cs (ram_evn_cs),
        .ram_odd_cs (ram_odd_cs),
        .rom_evn_cs (rom_evn_cs),
        .rom_odd_cs (rom_odd_cs),
        .duart_cs   (duart_cs),
        .berr_n     (berr_n),
        .overlay    (overlay)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // One bus cycle: as_n low for 'low' sampled edges, then raised.
    task automatic access(input string tag, input logic [4:0] a, input logic [2:0] f,
                          input logic r, input logic u, input logic l, input logic dt,
                          input int low, input logic [4:0] exp_cs);
        @(posedge clk); #1;
        addr = a; fc = f; rw = r; uds_n = u; lds_n = l; dtack_n = dt; as_n = 1'b0;
        @(negedge clk);
        check_eq({tag, " cs"}, 32'(cs), 32'(exp_cs));
        repeat (low) @(posedge clk);
        #1;
        as_n = 1'b1; dtack_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        #1;
        check_eq({tag, " cs released"}, 32'(cs), 32'h1f);
    endtask

    task automatic check_overlay_after(input string tag, input logic exp);
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, 32'(overlay), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; addr = '0; fc = 3'b110; as_n = 1'b1;
        uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; dtack_n = 1'b1;

        // Reset state, with a read strobe driven to prove selects are held off
        repeat (2) @(posedge clk);
        #1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        @(negedge clk);
        check_eq("reset cs", 32'(cs), 32'h1f);
        check_eq("reset berr_n", 32'(berr_n), 32'h1);
        check_eq("reset overlay", 32'(overlay), 32'h1);
        #1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1; reset = 1'b1;

        // Write during overlay selects RAM and does not count as a boot cycle
        access("ovl write 0x100", 5'b00000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5'b01111);
        access("boot read 1", 5'b00000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);
        access("boot read 2", 5'b00000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);
        access("boot read 3", 5'b00000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);
        check_overlay_after("overlay after 3 reads", 1'b1);
        access("boot read 4", 5'b00000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);
        check_overlay_after("overlay after 4 reads", 1'b0);
        access("ram read 0x08", 5'b00000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b00111);

        // Unmapped access: /BERR one edge after as_n falls
        @(posedge clk); #1;
        addr = 5'b01000; fc = 3'b101; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        dtack_n = 1'b1; as_n = 1'b0;
        @(negedge clk);
        check_eq("unmapped cs", 32'(cs), 32'h1f);
        check_eq("unmapped berr before edge", 32'(berr_n), 32'h1);
        @(negedge clk);
        check_eq("unmapped berr after 1 edge", 32'(berr_n), 32'h0);
        @(posedge clk); #1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("unmapped berr released", 32'(berr_n), 32'h1);

        // IACK to an otherwise unmapped address: no select, no /BERR
        @(posedge clk); #1;
        addr = 5'b01000; fc = 3'b111; dtack_n = 1'b0; as_n = 1'b0;
        @(negedge clk);
        check_eq("iack cs", 32'(cs), 32'h1f);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("iack berr_n", 32'(berr_n), 32'h1);
        #1; as_n = 1'b1; dtack_n = 1'b1;

        // DUART with no /DTACK: berr at edge 65, not 64
        @(posedge clk); #1;
        addr = 5'b11101; fc = 3'b101; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b0;
        dtack_n = 1'b1; as_n = 1'b0;
        @(negedge clk);
        check_eq("duart cs", 32'(cs), 32'b11110);
        repeat (64) @(posedge clk);
        @(negedge clk);
        check_eq("duart berr at 64", 32'(berr_n), 32'h1);
        @(posedge clk); @(negedge clk);
        check_eq("duart berr at 65", 32'(berr_n), 32'h0);
        #1; as_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("duart berr released", 32'(berr_n), 32'h1);

        // DUART answered at cycle 10: no /BERR however long the cycle
        @(posedge clk); #1;
        dtack_n = 1'b1; as_n = 1'b0;
        repeat (10) @(posedge clk);
        #1; dtack_n = 1'b0;
        repeat (70) @(posedge clk);
        @(negedge clk);
        check_eq("duart dtack berr_n", 32'(berr_n), 32'h1);
        check_eq("duart dtack cs", 32'(cs), 32'b11110);
        #1; as_n = 1'b1; dtack_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;

        // Re-arm overlay with reset; ROM-region read as 2nd boot cycle ends it
        @(posedge clk); #1; reset = 1'b0;
        #1; check_eq("reset re-arms overlay", 32'(overlay), 32'h1);
        @(posedge clk); #1; reset = 1'b1;
        access("boot2 read 1", 5'b00000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);
        check_overlay_after("overlay after 1 read", 1'b1);
        access("rom read 0xE00400", 5'b11100, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);
        check_overlay_after("overlay after rom read", 1'b0);
        access("ram read after rom", 5'b00000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b00111);

        // Reset asserted mid-cycle while berr_n is low
        @(posedge clk); #1;
        addr = 5'b01000; fc = 3'b101; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid berr low", 32'(berr_n), 32'h0);
        #1; reset = 1'b0;
        #1;
        check_eq("mid reset berr_n", 32'(berr_n), 32'h1);
        check_eq("mid reset overlay", 32'(overlay), 32'h1);
        check_eq("mid reset cs", 32'(cs), 32'h1f);
        @(posedge clk); #1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1; reset = 1'b1;
        access("post reset read 0", 5'b00000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b11001);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_decode.md
Name: bus_decode

Overview:
- Address decoder and bus-cycle supervisor for the 68000 bus.
- Sits directly upstream of the DTACK generator and drives its active-low chip selects: ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs and duart_cs.
- Maps ROM over low memory for the reset-vector fetch (boot overlay).
- Raises /BERR for unmapped accesses and for accesses that never receive /DTACK.

Parameters:
- BOOT_CYCLES, 4, number of completed read bus cycles during which the boot overlay stays active after reset.
- BERR_TIMEOUT, 64, clk cycles with as_n low and dtack_n high before berr_n asserts.
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > BERR_TIMEOUT.

Ports:
- clk  in  1  system clock; same clock as the CPU bus, so all bus inputs are synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- addr  in  5  CPU A[23:19].
- fc  in  3  CPU function code FC[2:0].
- as_n  in  1  address strobe, active-low.
- uds_n  in  1  upper data strobe, active-low.
- lds_n  in  1  lower data strobe, active-low.
- rw  in  1  1 = read, 0 = write.
- dtack_n  in  1  /DTACK as returned to the CPU from the DTACK generator.
- ram_evn_cs  out  1  active-low; even (upper) RAM byte.
- ram_odd_cs  out  1  active-low; odd (lower) RAM byte.
- rom_evn_cs  out  1  active-low; even (upper) ROM byte.
- rom_odd_cs  out  1  active-low; odd (lower) ROM byte.
- duart_cs  out  1  active-low; DUART select.
- berr_n  out  1  active-low bus error to the CPU.
- overlay  out  1  high while the boot overlay is active (status/debug).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset.
- Reset state (reset low):
  - All chip selects 1.
  - berr_n = 1.
  - overlay = 1.
  - Boot counter = 0; watchdog counter = 0.
- Memory map, decoded from addr:
  - RAM: 5'b00000, 5'b00001 (0x000000–0x0FFFFF).
  - ROM: 5'b11100 (0xE00000–0xE7FFFF).
  - DUART: 5'b11101 (0xE80000–0xEFFFFF).
  - Every other value is unmapped.
- Chip selects are combinational from current inputs and registered state, so they return to 1 in the same cycle as_n rises.
- IACK cycle (fc == 3'b111): no chip select asserts and the access is not treated as unmapped. The DUART's own /DTACK or autovector path completes it; the watchdog still runs.
- Overlay:
  - While overlay = 1, reads (rw = 1) to the RAM region assert the ROM selects instead of the RAM selects.
  - Writes to the RAM region always select RAM.
- Chip select equations:
  - ram_evn_cs = 0 iff as_n = 0, RAM decoded, not redirected, uds_n = 0. ram_odd_cs is the same with lds_n.
  - rom_evn_cs / rom_odd_cs are the same structure for the ROM region or an overlay-redirected read.
  - duart_cs = 0 iff as_n = 0 and the DUART region is decoded. Byte strobes are ignored for the DUART.
- Boot counter:
  - Detect the as_n rising edge with a registered copy of as_n.
  - Increment on each rising edge that ends a read cycle; rw is sampled in the last cycle as_n was low.
  - When the counter reaches BOOT_CYCLES, overlay clears on that clock edge.
  - overlay stays 0 until reset and is never re-armed by software.
  - A ROM-region access before the count completes also clears overlay at the end of that cycle.
- Watchdog state machine (IDLE, ACTIVE, BERR):
  - IDLE → ACTIVE on the first clk edge with as_n = 0; the counter loads 1.
  - ACTIVE with dtack_n = 0: hold; no berr.
  - ACTIVE with dtack_n = 1: counter increments.
  - ACTIVE → BERR when the counter == BERR_TIMEOUT.
  - ACTIVE → BERR on the first clk edge when the access is unmapped and fc != 3'b111, i.e. berr_n goes low 1 cycle after as_n falls.
  - In BERR, berr_n = 0 (registered).
  - Any state → IDLE on the clk edge where as_n = 1: berr_n returns to 1 and the counter clears.
  - as_n high for a single cycle between back-to-back accesses is sufficient to restart the watchdog.
  - The counter saturates and never wraps.
- Reset mid-cycle: all outputs return to their reset values immediately (asynchronously). After reset releases, the next read cycle counts as boot cycle 1.
- Latency summary:
  - Chip selects: 0 cycles from inputs.
  - berr_n: 1 cycle (unmapped) or BERR_TIMEOUT + 1 clk edges after as_n falls (timeout).

Test Plan:
- Reset release, then 4 reads at 0x000000/02/04/06 with uds_n = lds_n = 0 → rom_evn_cs and rom_odd_cs low during each; RAM selects stay high; overlay drops after the 4th as_n rise; a 5th read at 0x000008 asserts ram_evn_cs and ram_odd_cs.
- During overlay, a write to 0x000100 with uds_n = 0, lds_n = 1 → ram_evn_cs = 0, ram_odd_cs = 1, ROM selects high; boot count unchanged.
- Read at 0xE00400 as the 2nd boot cycle → ROM selected; overlay = 0 after as_n rises.
- Read at unmapped 0x400000 → no chip select; berr_n = 0 one clk after as_n falls; berr_n = 1 the cycle as_n rises.
- DUART access at 0xE80001 with dtack_n held high → duart_cs = 0; berr_n falls after 64 cycles; holding dtack_n low at cycle 10 instead yields no berr.
- Pull reset low while berr_n = 0 mid-cycle → berr_n = 1 and overlay = 1 immediately; the next read at 0x000000 selects ROM.
